data_register_arbiter: RTL



---
 rtl/data_register_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/data_register_arbiter.sv
// data_register_arbiter
//   Two-requester round-robin arbiter and sequencer in front of a single-port
//   data register storage array. Each transaction takes IDLE -> ACCESS ->
//   RESPOND; the winner gets a one-cycle ack in RESPOND and, for reads, its
//   rdata register is loaded from the storage's asynchronous read port.
//
// Ports
//   clock, reset            rising-edge clock, synchronous active-high reset
//   reqN/weN/addrN/wdataN   requester N command, held stable until ackN
//   ackN, rdataN            requester N completion pulse and read result
//   mem_*                   storage port (enable, addresses, write/read data)
//   busy                    high while a transaction is in flight
//   grant_id                current or most recent winner
module data_register_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  ack0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  mem_enable_write,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  busy,
  output logic                  grant_id
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  grant_id_q, grant_id_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic                  busy_q, busy_d;
  logic                  win;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    busy_d       = busy_q;
    win          = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // A lone request wins outright; under contention the requester
          // that did not win last time is served.
          win          = (req0 && req1) ? ~last_grant_q : req1;
          state_d      = ACCESS;
          busy_d       = 1'b1;
          grant_id_d   = win;
          last_grant_d = win;
          mem_we_d     = win ? we1 : we0;
          mem_addr_d   = win ? addr1 : addr0;
          mem_wdata_d  = win ? wdata1 : wdata0;
        end
      end
      ACCESS: begin
        state_d = RESPOND;
        // The write enable register doubles as the latched command type:
        // it is only ever high during ACCESS and only for writes.
        if (!mem_we_q) begin
          if (grant_id_q) rdata1_d = mem_read_data;
          else            rdata0_d = mem_read_data;
        end
        ack0_d = ~grant_id_q;
        ack1_d = grant_id_q;
      end
      RESPOND: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      busy_q       <= busy_d;
    end
  end

  assign ack0             = ack0_q;
  assign ack1             = ack1_q;
  assign rdata0           = rdata0_q;
  assign rdata1           = rdata1_q;
  assign mem_enable_write = mem_we_q;
  assign mem_write_addr   = mem_addr_q;
  assign mem_read_addr    = mem_addr_q;
  assign mem_write_data   = mem_wdata_q;
  assign busy             = busy_q;
  assign grant_id         = grant_id_q;

endmodule
